// File: rtl/wb_arbiter_pkg.sv
// Shared Wishbone slice definitions: bus-width defaults taken from the config defines,
// the master identifier type and the watchdog counter sizing helper.
`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif
`ifndef WB_DATA_W
`define WB_DATA_W 16
`endif
`ifndef WB_SEL_BITS
`define WB_SEL_BITS 2
`endif

package wb_arbiter_pkg;

  localparam int WB_ADDR_W_DEF = `WB_ADDR_W;
  localparam int WB_DATA_W_DEF = `WB_DATA_W;
  localparam int WB_SEL_W_DEF  = `WB_SEL_BITS;

  typedef enum logic {
    MST0 = 1'b0,
    MST1 = 1'b1
  } mst_e;

  // Smallest counter width that can hold the value 'limit'.
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Slave stall watchdog: counts stalled strobe cycles while a master owns the bus and
// raises a single-cycle timeout when the count reaches TMO.
module wb_watchdog
  import wb_arbiter_pkg::*;
#(
  parameter int TMO = 255
) (
  input  logic d_clk,
  input  logic i_rst,
  input  logic busy_i,
  input  logic stb_i,
  input  logic ack_i,
  input  logic err_i,
  output logic tmo_err_o
);

  localparam int CNT_W = cnt_width(TMO);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TMO);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_limit;
  logic             stall;

  assign at_limit  = (cnt_q == LIMIT);
  assign stall     = busy_i & stb_i & ~ack_i & ~err_i;
  // A slave ack landing on the terminal cycle wins over the timeout.
  assign tmo_err_o = busy_i & at_limit & ~ack_i;

  always_comb begin
    cnt_d = cnt_q;
    if (!busy_i || ack_i || err_i || at_limit) begin
      cnt_d = '0;
    end else if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge d_clk) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter with locked-cycle grants, round-robin on contention and a
// stall watchdog that converts a silent slave into a bus error for the owning master.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W_DEF,
  parameter int DATA_W = WB_DATA_W_DEF,
  parameter int SEL_W  = WB_SEL_W_DEF,
  parameter int TMO    = 255
) (
  input  logic              d_clk,
  input  logic              i_rst,
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [DATA_W-1:0] m0_o_dat,
  input  logic [SEL_W-1:0]  m0_sel,
  output logic [DATA_W-1:0] m0_i_dat,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [DATA_W-1:0] m1_o_dat,
  input  logic [SEL_W-1:0]  m1_sel,
  output logic [DATA_W-1:0] m1_i_dat,
  output logic              m1_ack,
  output logic              m1_err,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_adr,
  output logic [DATA_W-1:0] s_o_dat,
  output logic [SEL_W-1:0]  s_sel,
  input  logic [DATA_W-1:0] s_i_dat,
  input  logic              s_ack,
  input  logic              s_err,
  output logic [1:0]        o_gnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS0 = 2'd1;
  localparam logic [1:0] ST_BUS1 = 2'd2;

  logic [1:0]        state_q, state_d;
  mst_e              last_gnt_q, last_gnt_d;
  logic              req0, req1;
  logic              bus0, bus1;
  logic              tmo_err;
  logic              mux_cyc, mux_stb, mux_we;
  logic [ADDR_W-1:0] mux_adr;
  logic [DATA_W-1:0] mux_dat;
  logic [SEL_W-1:0]  mux_sel;

  assign req0 = m0_cyc & m0_stb;
  assign req1 = m1_cyc & m1_stb;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1) begin
          state_d = (last_gnt_q == MST1) ? ST_BUS0 : ST_BUS1;
        end else if (req0) begin
          state_d = ST_BUS0;
        end else if (req1) begin
          state_d = ST_BUS1;
        end
      end
      ST_BUS0: begin
        if (!m0_cyc) begin
          state_d    = ST_IDLE;
          last_gnt_d = MST0;
        end
      end
      ST_BUS1: begin
        if (!m1_cyc) begin
          state_d    = ST_IDLE;
          last_gnt_d = MST1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge d_clk) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= MST1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Reset also gates the grant combinationally so outputs drop in the reset cycle itself.
  assign bus0  = i_rst & (state_q == ST_BUS0);
  assign bus1  = i_rst & (state_q == ST_BUS1);
  assign o_gnt = {bus1, bus0};

  always_comb begin
    mux_cyc = 1'b0;
    mux_stb = 1'b0;
    mux_we  = 1'b0;
    mux_adr = '0;
    mux_dat = '0;
    mux_sel = '0;
    if (bus0) begin
      mux_cyc = m0_cyc;
      mux_stb = m0_cyc & m0_stb;
      mux_we  = m0_we;
      mux_adr = m0_adr;
      mux_dat = m0_o_dat;
      mux_sel = m0_sel;
    end else if (bus1) begin
      mux_cyc = m1_cyc;
      mux_stb = m1_cyc & m1_stb;
      mux_we  = m1_we;
      mux_adr = m1_adr;
      mux_dat = m1_o_dat;
      mux_sel = m1_sel;
    end
  end

  wb_watchdog #(
    .TMO(TMO)
  ) u_watchdog (
    .d_clk    (d_clk),
    .i_rst    (i_rst),
    .busy_i   (mux_cyc),
    .stb_i    (mux_stb),
    .ack_i    (s_ack),
    .err_i    (s_err),
    .tmo_err_o(tmo_err)
  );

  assign s_cyc   = mux_cyc;
  assign s_stb   = mux_stb & ~tmo_err;
  assign s_we    = mux_we;
  assign s_adr   = mux_adr;
  assign s_o_dat = mux_dat;
  assign s_sel   = mux_sel;

  assign m0_ack   = bus0 & s_ack;
  assign m0_err   = bus0 & (s_err | tmo_err);
  assign m0_i_dat = bus0 ? s_i_dat : '0;
  assign m1_ack   = bus1 & s_ack;
  assign m1_err   = bus1 & (s_err | tmo_err);
  assign m1_i_dat = bus1 ? s_i_dat : '0;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, Wishbone address width.
REQ-002 SHALL have parameter DATA_W, default 16, Wishbone data width.
REQ-003 SHALL have parameter SEL_W, default 2, byte-select width.
REQ-004 SHALL have parameter TMO, default 255, stall cycles before bus error.
REQ-005 SHALL have port d_clk, input, 1 bit: clock, all logic on the rising edge.
REQ-006 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have inputs mN_cyc (1), mN_stb (1), mN_we (1), mN_adr (ADDR_W), mN_o_dat (DATA_W) and mN_sel (SEL_W), for N=0,1: master N request.
REQ-008 SHALL have outputs mN_i_dat (DATA_W), mN_ack (1) and mN_err (1), for N=0,1: master N response.
REQ-009 SHALL have outputs s_cyc (1), s_stb (1), s_we (1), s_adr (ADDR_W), s_o_dat (DATA_W) and s_sel (SEL_W): shared slave request.
REQ-010 SHALL have inputs s_i_dat (DATA_W), s_ack (1) and s_err (1): shared slave response.
REQ-011 SHALL have output o_gnt, 2 bits: one-hot current grant, 00 when idle.

Function
REQ-012 SHALL implement FSM states IDLE, BUS0 and BUS1, held in a registered state.
REQ-013 In IDLE, with a request (mN_cyc&mN_stb) from exactly one master, SHALL go to that master's BUSN next cycle.
REQ-014 In IDLE, with both masters requesting, SHALL grant the master that is not last_gnt (round-robin).
REQ-015 In BUSN, SHALL hold the grant while mN_cyc=1, including across multiple stb/ack beats (locked cycle).
REQ-016 In BUSN, when mN_cyc=0, SHALL go to IDLE next cycle and set last_gnt=N.
REQ-017 Grant latency SHALL be 1 cycle: a request at cycle t drives s_stb at t+1 at the earliest.
REQ-018 Re-arbitration SHALL take 1 idle cycle: no back-to-back grants without passing through IDLE.
REQ-019 Request and response muxing SHALL be combinational on the registered state; no added data latency.
REQ-020 In IDLE, s_cyc and s_stb SHALL be 0.
REQ-021 The non-granted master SHALL see ack=0, err=0 and i_dat=0.
REQ-022 The granted master SHALL see mN_ack=s_ack, mN_err=s_err|tmo_err and mN_i_dat=s_i_dat.
REQ-023 The watchdog SHALL count cycles with s_stb=1, s_ack=0 and s_err=0 in BUSN.
REQ-024 The watchdog counter SHALL clear on ack, on err, or on leaving BUSN.
REQ-025 The watchdog counter SHALL saturate and never wrap.
REQ-026 When the counter reaches TMO, SHALL pulse tmo_err for exactly 1 cycle, mask s_stb to 0 in that cycle, then clear the counter.
REQ-027 If s_ack and tmo_err coincide, ack SHALL win: err is suppressed and the counter is cleared.
REQ-028 If mN_cyc drops mid-stall, SHALL return to IDLE and mask s_stb the following cycle.
REQ-029 A request arriving in the same cycle the other master drops cyc SHALL be granted after the IDLE cycle per REQ-014.

Reset
REQ-030 While i_rst=0 at a clock edge: state=IDLE, last_gnt=1 (master 0 wins first contention), watchdog=0, tmo_err=0.
REQ-031 During reset, all outputs SHALL be 0: s_cyc, s_stb, s_we, s_adr, s_o_dat, s_sel, mN_ack, mN_err, mN_i_dat and o_gnt.
REQ-032 Reset asserted mid-transfer SHALL abort the grant immediately, with no err pulse.

Structure
REQ-033 Bus widths SHALL come from the shared config.v defines (WB_ADDR_W, WB_DATA_W, WB_SEL_BITS) at instantiation.
REQ-034 FSM state encoding SHALL be local localparams, not shared.
REQ-035 The watchdog SHALL be one sub-module, wb_watchdog (counter, compare, single-cycle pulse).
REQ-036 The arbiter SHALL be instantiated between wb_decomp/second requester and the SDRAM/ROM/UART decode.

Verification
REQ-037 Single master: m0 requests at t=0 with adr=24'h100010 and s_ack at t=3 -> o_gnt=01 at t=1, s_stb at t=1..3, m0_ack at t=3, IDLE at t+1 after m0_cyc drops.
REQ-038 Contention after reset: m0 and m1 both request at t=0 -> m0 granted; after m0 releases, m1 granted 1 idle cycle later.
REQ-039 Round-robin: after m1 completes, both request again -> m0 granted; repeat 4 times -> grants alternate strictly.
REQ-040 Timeout with TMO=8: slave never acks -> m0_err high exactly one cycle, 8 cycles after s_stb rises; s_stb=0 in that cycle; m1_err stays 0.
REQ-041 Ack/timeout collision: s_ack on the cycle the counter reaches TMO -> m0_ack=1 and m0_err=0.
REQ-042 Reset mid-transfer: i_rst=0 while in BUS1 -> next cycle o_gnt=00, s_cyc=0, no err; m0 granted first after reset.
